// File: rtl/c7b_lsu_wbuf_pkg.sv
// rtl/c7b_lsu_wbuf_pkg.sv - shared drain-FSM state encodings and entry width for the LSU store buffer
package c7b_lsu_wbuf_pkg;

  typedef enum logic [1:0] {
    WBUF_IDLE   = 2'd0,
    WBUF_ISSUE  = 2'd1,
    WBUF_WAIT_B = 2'd2
  } wbuf_state_e;

  // One buffered store is {addr, data, strb}.
  function automatic int entry_width(input int aw, input int dw);
    return aw + dw + dw / 8;
  endfunction

endpackage

// File: rtl/c7b_wbuf_fifo.sv
// rtl/c7b_wbuf_fifo.sv - in-order store storage with per-entry valid bits and line-address bus
module c7b_wbuf_fifo
  import c7b_lsu_wbuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [AW-1:0]              push_addr,
  input  logic [DW-1:0]              push_data,
  input  logic [DW/8-1:0]            push_strb,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DEPTH-1:0]           valid,
  output logic [DEPTH*(AW-3)-1:0]    line_bus,
  output logic [AW-1:0]              head_addr,
  output logic [DW-1:0]              head_data,
  output logic [DW/8-1:0]            head_strb
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = entry_width(AW, DW);
  localparam int LW = AW - 3;

  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr;
  logic [DEPTH-1:0] valid_d;

  always_comb begin
    valid_d = valid;
    if (push) valid_d[wptr] = 1'b1;
    if (pop)  valid_d[rptr] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      valid <= valid_d;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset; valid bits guard every read of it.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {push_addr, push_data, push_strb};
  end

  assign {head_addr, head_data, head_strb} = mem[rptr];

  for (genvar i = 0; i < DEPTH; i++) begin : g_line
    assign line_bus[i*LW +: LW] = mem[i][EW-1 -: LW];
  end

endmodule

// File: rtl/c7b_lsu_wbuf.sv
// rtl/c7b_lsu_wbuf.sv - posted store buffer draining single-beat AXI writes from LSU to BIU
module c7b_lsu_wbuf
  import c7b_lsu_wbuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lsu_wbuf_wr_req,
  input  logic [AW-1:0]   lsu_wbuf_wr_addr,
  input  logic [DW-1:0]   lsu_wbuf_wr_data,
  input  logic [DW/8-1:0] lsu_wbuf_wr_strb,
  output logic            wbuf_lsu_wr_ack,
  input  logic [AW-1:0]   lsu_wbuf_rd_addr,
  output logic            wbuf_lsu_rd_hazard,
  output logic            wbuf_lsu_empty,
  output logic            wbuf_biu_wr_aw_req,
  output logic [AW-1:0]   wbuf_biu_wr_addr,
  output logic            wbuf_biu_wr_w_req,
  output logic [DW-1:0]   wbuf_biu_wr_data,
  output logic [DW/8-1:0] wbuf_biu_wr_strb,
  output logic            wbuf_biu_wr_last,
  input  logic            biu_wbuf_wr_aw_ack,
  input  logic            biu_wbuf_wr_w_ack,
  input  logic            biu_wbuf_write_done
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int LW = AW - 3;

  wbuf_state_e          state, state_d;
  logic                 aw_pend, aw_pend_d;
  logic                 w_pend, w_pend_d;
  logic                 pop;
  logic [CW-1:0]        count;
  logic [DEPTH-1:0]     valid;
  logic [DEPTH*LW-1:0]  line_bus;
  logic                 unused_rd_lsb;

  assign wbuf_lsu_wr_ack  = lsu_wbuf_wr_req && (count < CW'(DEPTH));
  assign wbuf_lsu_empty   = (count == '0);
  assign wbuf_biu_wr_last = 1'b1;
  assign unused_rd_lsb    = ^lsu_wbuf_rd_addr[2:0];

  c7b_wbuf_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wbuf_lsu_wr_ack),
    .push_addr (lsu_wbuf_wr_addr),
    .push_data (lsu_wbuf_wr_data),
    .push_strb (lsu_wbuf_wr_strb),
    .pop       (pop),
    .count     (count),
    .valid     (valid),
    .line_bus  (line_bus),
    .head_addr (wbuf_biu_wr_addr),
    .head_data (wbuf_biu_wr_data),
    .head_strb (wbuf_biu_wr_strb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= WBUF_IDLE;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else begin
      state   <= state_d;
      aw_pend <= aw_pend_d;
      w_pend  <= w_pend_d;
    end
  end

  always_comb begin
    state_d            = state;
    aw_pend_d          = aw_pend;
    w_pend_d           = w_pend;
    wbuf_biu_wr_aw_req = 1'b0;
    wbuf_biu_wr_w_req  = 1'b0;
    pop                = 1'b0;
    case (state)
      WBUF_IDLE: begin
        if (count != '0) begin
          state_d   = WBUF_ISSUE;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
        end
      end
      WBUF_ISSUE: begin
        // AW and W complete independently; B is awaited only once both are gone.
        wbuf_biu_wr_aw_req = aw_pend;
        wbuf_biu_wr_w_req  = w_pend;
        aw_pend_d          = aw_pend && !biu_wbuf_wr_aw_ack;
        w_pend_d           = w_pend && !biu_wbuf_wr_w_ack;
        if (!aw_pend_d && !w_pend_d) state_d = WBUF_WAIT_B;
      end
      WBUF_WAIT_B: begin
        if (biu_wbuf_write_done) begin
          pop     = 1'b1;
          state_d = WBUF_IDLE;
        end
      end
      default: state_d = WBUF_IDLE;
    endcase
  end

  // The head stays visible to loads until its B response pops it.
  always_comb begin
    wbuf_lsu_rd_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (line_bus[i*LW +: LW] == lsu_wbuf_rd_addr[AW-1:3]))
        wbuf_lsu_rd_hazard = 1'b1;
    end
  end

  a_done_only_in_wait_b: assert property (@(posedge clk) disable iff (reset)
    biu_wbuf_write_done |-> (state == WBUF_WAIT_B));

endmodule

// File: tb/tb_c7b_lsu_wbuf.sv
// tb/tb_c7b_lsu_wbuf.sv - self-checking bench for c7b_lsu_wbuf with table vectors and a store scoreboard
module tb_c7b_lsu_wbuf;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_req = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [7:0]  wr_strb = '0;
  logic        wr_ack;
  logic [31:0] rd_addr = 32'hFFFF_FFF0;
  logic        rd_hazard;
  logic        empty;
  logic        aw_req;
  logic [31:0] biu_addr;
  logic        w_req;
  logic [63:0] biu_data;
  logic [7:0]  biu_strb;
  logic        biu_last;
  logic        aw_ack = 1'b0;
  logic        w_ack = 1'b0;
  logic        write_done = 1'b0;

  c7b_lsu_wbuf dut (
    .clk                (clk),
    .reset              (reset),
    .lsu_wbuf_wr_req    (wr_req),
    .lsu_wbuf_wr_addr   (wr_addr),
    .lsu_wbuf_wr_data   (wr_data),
    .lsu_wbuf_wr_strb   (wr_strb),
    .wbuf_lsu_wr_ack    (wr_ack),
    .lsu_wbuf_rd_addr   (rd_addr),
    .wbuf_lsu_rd_hazard (rd_hazard),
    .wbuf_lsu_empty     (empty),
    .wbuf_biu_wr_aw_req (aw_req),
    .wbuf_biu_wr_addr   (biu_addr),
    .wbuf_biu_wr_w_req  (w_req),
    .wbuf_biu_wr_data   (biu_data),
    .wbuf_biu_wr_strb   (biu_strb),
    .wbuf_biu_wr_last   (biu_last),
    .biu_wbuf_wr_aw_ack (aw_ack),
    .biu_wbuf_wr_w_ack  (w_ack),
    .biu_wbuf_write_done(write_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } st_t;

  typedef struct {
    st_t  st;
    logic exp_ack;
  } enq_vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        exp_hz;
  } hz_vec_t;

  st_t sb[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc_n = 0;
  int  wd_cyc = -1;
  int  ack_cyc = -1;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of store request; caller decides when to drop wr_req.
  task automatic store(input st_t s, input logic exp_ack);
    wr_req  = 1'b1;
    wr_addr = s.addr;
    wr_data = s.data;
    wr_strb = s.strb;
    #1;
    chk("wr_ack", wr_ack, exp_ack);
    if (wr_ack) sb.push_back(s);
    tick();
  endtask

  task automatic wait_issue();
    bit seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (aw_req) seen = 1;
      else tick();
    end
    chk("issue_timeout", seen, 1'b1);
  endtask

  // BIU model for one write: acks after aw_d/w_d cycles, B after b_d cycles in WAIT_B.
  task automatic serve(input int aw_d, input int w_d, input int b_d);
    int  naw = 0, nw = 0, nb = 0;
    bit  got = 0, aw_sent = 0, w_sent = 0, fin = 0;
    st_t e;
    e.addr = '0; e.data = '0; e.strb = '0;
    for (int c = 0; c < 100 && !fin; c++) begin
      aw_ack = 0; w_ack = 0; write_done = 0;
      #1;
      if ((aw_req || w_req) && !got) begin
        chk("sb_has_entry", sb.size() > 0, 1'b1);
        if (sb.size() > 0) e = sb.pop_front();
        got = 1;
      end
      if (aw_req && !aw_sent) begin
        chk("aw_addr", biu_addr, e.addr);
        if (naw == aw_d) begin aw_ack = 1; aw_sent = 1; end
        else naw++;
      end
      if (w_req && !w_sent) begin
        chk("w_data", biu_data, e.data);
        chk("w_strb", biu_strb, e.strb);
        chk("w_last", biu_last, 1'b1);
        if (nw == w_d) begin w_ack = 1; w_sent = 1; end
        else nw++;
      end
      if (got && aw_sent && w_sent && !aw_req && !w_req && !aw_ack && !w_ack) begin
        if (nb == b_d) begin write_done = 1; fin = 1; wd_cyc = cyc_n; end
        else nb++;
      end
      tick();
    end
    aw_ack = 0; w_ack = 0; write_done = 0;
    chk("serve_done", fin, 1'b1);
  endtask

  enq_vec_t enq_tab[5];
  hz_vec_t  hz_tab[5];

  initial begin
    st_t s;

    enq_tab[0] = '{'{32'h3000_0000, 64'hA0, 8'hFF}, 1'b1};
    enq_tab[1] = '{'{32'h3000_0008, 64'hA1, 8'h0F}, 1'b1};
    enq_tab[2] = '{'{32'h3000_0010, 64'hA2, 8'hF0}, 1'b1};
    enq_tab[3] = '{'{32'h3000_0018, 64'hA3, 8'h01}, 1'b1};
    enq_tab[4] = '{'{32'h3000_0020, 64'hA4, 8'h80}, 1'b0};
    hz_tab[0]  = '{32'h2000_0014, 1'b1};
    hz_tab[1]  = '{32'h2000_0018, 1'b0};
    hz_tab[2]  = '{32'h2000_0010, 1'b1};
    hz_tab[3]  = '{32'h2000_0017, 1'b1};
    hz_tab[4]  = '{32'h1000_0010, 1'b0};

    // Reset state
    tick(); tick();
    reset = 1'b0;
    tick();
    #1;
    chk("rst_aw_req", aw_req, 1'b0);
    chk("rst_w_req", w_req, 1'b0);
    chk("rst_wr_ack", wr_ack, 1'b0);
    chk("rst_hazard", rd_hazard, 1'b0);
    chk("rst_empty", empty, 1'b1);
    tick();

    // Single store: acked same cycle, reqs two cycles later, empty after B
    s = '{32'h1000_0008, 64'h1122334455667788, 8'hFF};
    store(s, 1'b1);
    wr_req = 1'b0;
    #1;
    chk("t1_aw_c1", aw_req, 1'b0);
    chk("t1_empty_c1", empty, 1'b0);
    tick();
    #1;
    chk("t1_aw_c2", aw_req, 1'b1);
    chk("t1_w_c2", w_req, 1'b1);
    chk("t1_addr", biu_addr, 32'h1000_0008);
    chk("t1_data", biu_data, 64'h1122334455667788);
    chk("t1_strb", biu_strb, 8'hFF);
    aw_ack = 1; w_ack = 1;
    tick();
    aw_ack = 0; w_ack = 0;
    #1;
    chk("t1_aw_waitb", aw_req, 1'b0);
    chk("t1_w_waitb", w_req, 1'b0);
    tick();
    tick();
    write_done = 1;
    #1;
    chk("t1_empty_at_b", empty, 1'b0);
    tick();
    write_done = 0;
    #1;
    chk("t1_empty_after_b", empty, 1'b1);
    sb.delete();
    tick();

    // Split acks: W first, AW two cycles later
    s = '{32'h1000_0040, 64'hDEAD_BEEF_0000_0001, 8'h3C};
    store(s, 1'b1);
    wr_req = 1'b0;
    wait_issue();
    chk("t3_w_c0", w_req, 1'b1);
    tick();
    w_ack = 1;
    #1;
    chk("t3_aw_c1", aw_req, 1'b1);
    chk("t3_w_c1", w_req, 1'b1);
    tick();
    w_ack = 0;
    #1;
    chk("t3_w_c2", w_req, 1'b0);
    chk("t3_aw_c2", aw_req, 1'b1);
    tick();
    aw_ack = 1;
    #1;
    chk("t3_aw_c3", aw_req, 1'b1);
    chk("t3_addr_c3", biu_addr, 32'h1000_0040);
    tick();
    aw_ack = 0;
    #1;
    chk("t3_aw_c4", aw_req, 1'b0);
    chk("t3_w_c4", w_req, 1'b0);
    chk("t3_empty_c4", empty, 1'b0);
    write_done = 1;
    tick();
    write_done = 0;
    #1;
    chk("t3_empty_c5", empty, 1'b1);
    sb.delete();
    tick();

    // Hazard: same-cycle enqueue is invisible, then table of load addresses
    wr_req = 1'b1; wr_addr = 32'h2000_0010; wr_data = 64'h55; wr_strb = 8'hFF;
    rd_addr = 32'h2000_0014;
    #1;
    chk("t4_ack", wr_ack, 1'b1);
    chk("t4_hz_same_cycle", rd_hazard, 1'b0);
    if (wr_ack) sb.push_back('{32'h2000_0010, 64'h55, 8'hFF});
    tick();
    wr_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd_addr = hz_tab[i].rd;
      #1;
      chk($sformatf("t4_hz_%0d", i), rd_hazard, hz_tab[i].exp_hz);
      tick();
    end
    rd_addr = 32'hFFFF_FFF0;
    serve(0, 0, 0);
    rd_addr = 32'h2000_0014;
    #1;
    chk("t4_hz_after_pop", rd_hazard, 1'b0);
    rd_addr = 32'hFFFF_FFF0;
    tick();

    // Full buffer: 5th store held until the cycle after the first B
    for (int i = 0; i < 5; i++) store(enq_tab[i].st, enq_tab[i].exp_ack);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_full_noack", wr_ack, 1'b0);
      chk("t2_full_empty", empty, 1'b0);
      tick();
    end
    serve(1, 0, 2);
    #1;
    if (wr_ack) begin
      sb.push_back(enq_tab[4].st);
      ack_cyc = cyc_n;
    end
    chk("t2_ack_after_b", ack_cyc, wd_cyc + 1);
    tick();
    wr_req = 1'b0;
    for (int i = 0; i < 4; i++) serve(0, 1, 0);
    #1;
    chk("t2_empty", empty, 1'b1);
    tick();

    // Reset during ISSUE with three stores buffered
    for (int i = 0; i < 3; i++) store('{32'h4000_0000 + 32'(i * 8), 64'(i), 8'hFF}, 1'b1);
    wr_req = 1'b0;
    wait_issue();
    reset = 1'b1;
    #1;
    chk("t5_aw_rst", aw_req, 1'b0);
    chk("t5_w_rst", w_req, 1'b0);
    chk("t5_empty_rst", empty, 1'b1);
    sb.delete();
    tick();
    reset = 1'b0;
    tick();
    store('{32'h4000_0100, 64'hCAFE, 8'h0F}, 1'b1);
    wr_req = 1'b0;
    serve(0, 0, 1);
    #1;
    chk("t5_empty_after", empty, 1'b1);
    tick();

    // Random BIU delays, pointers wrap past the end
    for (int i = 0; i < 4; i++)
      store('{32'(i * 8), {$urandom, $urandom}, 8'($urandom_range(1, 255))}, 1'b1);
    wr_req = 1'b0;
    for (int i = 0; i < 4; i++)
      serve($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    #1;
    chk("t6_empty", empty, 1'b1);
    chk("t6_sb_drained", sb.size(), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
